// File: rtl/maszyna_stanow_pkg.sv
// maszyna_stanow_pkg: shared widths and state encoding for the serial transmitter
package maszyna_stanow_pkg;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 5;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
endpackage

// File: rtl/maszyna_stanow.sv
// maszyna_stanow: start/8-data/stop serial transmitter, LSB first, registered txd
module maszyna_stanow #(
    parameter int DATA_W = maszyna_stanow_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] data,
    output logic              txd,
    output logic [1:0]        state_test,
    output logic [4:0]        cnt_test
);
    import maszyna_stanow_pkg::*;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              txd_n;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            txd   <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            txd   <= txd_n;
        end
    end
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = send ? START : IDLE;
            START:   state_n = DATA;
            DATA:    state_n = (cnt == LAST) ? STOP : DATA;
            default: state_n = IDLE;
        endcase
    end
    // txd is registered, so it is computed from the state being entered
    always_comb begin
        cnt_n = (state == DATA && state_n == DATA) ? cnt + 1'b1 : '0;
        sh_n  = (state == IDLE && send) ? data : (state_n == DATA) ? sh >> 1 : sh;
        txd_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? sh[0] : 1'b1;
    end
    assign state_test = state;
    assign cnt_test   = cnt;
endmodule

// File: tb/tb_maszyna_stanow.sv
// tb_maszyna_stanow: table-driven vectors plus hand sequences for the serial transmitter
module tb_maszyna_stanow;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic       txd;
    logic [1:0] state_test;
    logic [4:0] cnt_test;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic       send;
        logic [7:0] data;
        logic [1:0] st;
        logic [4:0] cnt;
        logic       txd;
    } vec_t;

    vec_t tbl[$];

    maszyna_stanow #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .send(send), .data(data),
        .txd(txd), .state_test(state_test), .cnt_test(cnt_test)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] st, input logic [4:0] c, input logic t);
        chk({name, " state"}, {6'd0, state_test}, {6'd0, st});
        chk({name, " cnt"}, {3'd0, cnt_test}, {3'd0, c});
        chk({name, " txd"}, {7'd0, txd}, {7'd0, t});
    endtask

    function automatic vec_t mk(input logic s, input logic [7:0] d, input logic [1:0] st,
                                input logic [4:0] c, input logic t);
        vec_t v;
        v.send = s; v.data = d; v.st = st; v.cnt = c; v.txd = t;
        return v;
    endfunction

    // full frame with expected bits taken from b; data switches to alt after acceptance
    task automatic send_frame(input string name, input logic [7:0] b, input logic [7:0] alt);
        send = 1'b1;
        data = b;
        tick();
        send = 1'b0;
        data = alt;
        chk_all({name, " start"}, 2'd1, 5'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_all($sformatf("%s bit%0d", name, k), 2'd2, 5'(k), b[k]);
        end
        tick();
        chk_all({name, " stop"}, 2'd3, 5'd0, 1'b1);
        tick();
        chk_all({name, " idle"}, 2'd0, 5'd0, 1'b1);
    endtask

    initial begin
        // frame 0x41: 0,1,0,0,0,0,0,1,0,1
        tbl.push_back(mk(1, 8'h41, 1, 0, 0));
        tbl.push_back(mk(0, 8'h41, 2, 0, 1));
        tbl.push_back(mk(0, 8'h41, 2, 1, 0));
        tbl.push_back(mk(0, 8'h41, 2, 2, 0));
        tbl.push_back(mk(0, 8'h41, 2, 3, 0));
        tbl.push_back(mk(0, 8'h41, 2, 4, 0));
        tbl.push_back(mk(0, 8'h41, 2, 5, 0));
        tbl.push_back(mk(0, 8'h41, 2, 6, 1));
        tbl.push_back(mk(0, 8'h41, 2, 7, 0));
        tbl.push_back(mk(0, 8'h41, 3, 0, 1));
        tbl.push_back(mk(0, 8'h41, 0, 0, 1));
        tbl.push_back(mk(0, 8'h41, 0, 0, 1));
        // frame 0x3C with data changed and send held high while busy, also through STOP
        tbl.push_back(mk(1, 8'h3C, 1, 0, 0));
        tbl.push_back(mk(0, 8'hFF, 2, 0, 0));
        tbl.push_back(mk(0, 8'hFF, 2, 1, 0));
        tbl.push_back(mk(0, 8'hFF, 2, 2, 1));
        tbl.push_back(mk(1, 8'hFF, 2, 3, 1));
        tbl.push_back(mk(1, 8'hFF, 2, 4, 1));
        tbl.push_back(mk(1, 8'hFF, 2, 5, 1));
        tbl.push_back(mk(0, 8'hFF, 2, 6, 0));
        tbl.push_back(mk(1, 8'hFF, 2, 7, 0));
        tbl.push_back(mk(1, 8'hFF, 3, 0, 1));
        tbl.push_back(mk(1, 8'hFF, 0, 0, 1));
        // earliest acceptance: 11 cycles after the previous one
        tbl.push_back(mk(1, 8'h80, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 2, 0, 0));
        tbl.push_back(mk(0, 8'h00, 2, 1, 0));
        tbl.push_back(mk(0, 8'h00, 2, 2, 0));
        tbl.push_back(mk(0, 8'h00, 2, 3, 0));
        tbl.push_back(mk(0, 8'h00, 2, 4, 0));
        tbl.push_back(mk(0, 8'h00, 2, 5, 0));
        tbl.push_back(mk(0, 8'h00, 2, 6, 0));
        tbl.push_back(mk(0, 8'h00, 2, 7, 1));
        tbl.push_back(mk(0, 8'h00, 3, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1));

        // asynchronous reset with no clock edge yet
        #2 rst = 1'b0;
        #1 chk_all("reset async", 2'd0, 5'd0, 1'b1);
        send = 1'b1;
        data = 8'hFF;
        tick();
        chk_all("reset held", 2'd0, 5'd0, 1'b1);
        rst = 1'b1;
        send = 1'b0;
        tick();
        chk_all("idle no send", 2'd0, 5'd0, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            send = tbl[i].send;
            data = tbl[i].data;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].cnt, tbl[i].txd);
        end
        send = 1'b0;

        send_frame("datachg", 8'hA5, 8'h5A);

        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'(i * 37 + 11);
            send_frame($sformatf("b2b%0d", i), b, ~b);
            tick();
            chk_all($sformatf("b2b%0d gap", i), 2'd0, 5'd0, 1'b1);
        end

        // mid-frame reset at cnt=5
        send = 1'b1;
        data = 8'h00;
        tick();
        send = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk_all("pre abort", 2'd2, 5'd5, 1'b0);
        #2 rst = 1'b0;
        #1 chk_all("abort", 2'd0, 5'd0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        chk_all("after abort", 2'd0, 5'd0, 1'b1);
        send_frame("post reset", 8'hC3, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
